// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product read sequencer.
// Holds the FSM state encoding, the default word/address widths and the
// accumulator width derivation used by dot_product_ctrl and dp_mac.
package dp_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  // Sum of 2**aw products of two dw-bit words fits in 2*dw+aw bits.
  function automatic int acc_width(input int dw, input int aw);
    return 2 * dw + aw;
  endfunction

  localparam int ACC_WIDTH_DEF = acc_width(DATA_WIDTH_DEF, ADDR_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dp_mac.sv
// Registered unsigned multiply-accumulate.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the accumulator (has priority over en)
//   en         : add a*b into the accumulator on this edge
//   a, b       : unsigned operands
//   sum        : accumulator plus the current product (the value loaded when en=1)
module dp_mac
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  sum
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    acc;

  assign prod = a * b;
  assign sum  = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product read sequencer for two registered-read memories (A and B).
// Issues paired read addresses, absorbs the one-cycle read latency,
// accumulates the products and returns the sum over a valid/ready handshake.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   start, len, a_base, b_base       : request (sampled only in IDLE)
//   busy                             : not in IDLE
//   err                              : one-cycle pulse on start with illegal len
//   a_read_en/a_read_address/a_data  : memory A read port
//   b_read_en/b_read_address/b_data  : memory B read port
//   result/result_valid/result_ready : result handshake
module dot_product_ctrl
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  output logic                  busy,
  output logic                  err,
  output logic                  a_read_en,
  output logic [ADDR_WIDTH-1:0] a_read_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  b_read_en,
  output logic [ADDR_WIDTH-1:0] b_read_address,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH-1:0] a_base_q;
  logic [ADDR_WIDTH-1:0] b_base_q;
  logic                  vld_d1;
  logic                  len_ok;
  logic                  acc_clr;
  logic [ACC_WIDTH-1:0]  mac_sum;

  assign len_ok  = (len != '0) && (len <= MAX_LEN);
  assign acc_clr = (state == IDLE) && start && len_ok;

  // Read data arrives one cycle after the enable; vld_d1 qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d1 <= 1'b0;
    end else begin
      vld_d1 <= a_read_en;
    end
  end

  dp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (vld_d1),
    .a     (a_data),
    .b     (b_data),
    .sum   (mac_sum)
  );

  // idx holds the index of the next element to issue; element 0 is issued
  // straight from the IDLE transition so the first read overlaps ISSUE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      err            <= 1'b0;
      a_read_en      <= 1'b0;
      b_read_en      <= 1'b0;
      a_read_address <= '0;
      b_read_address <= '0;
      result         <= '0;
      result_valid   <= 1'b0;
      len_q          <= '0;
      idx            <= '0;
      a_base_q       <= '0;
      b_base_q       <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q          <= len;
              a_base_q       <= a_base;
              b_base_q       <= b_base;
              idx            <= {{ADDR_WIDTH{1'b0}}, 1'b1};
              a_read_en      <= 1'b1;
              b_read_en      <= 1'b1;
              a_read_address <= a_base;
              b_read_address <= b_base;
              busy           <= 1'b1;
              state          <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (idx == len_q) begin
            a_read_en <= 1'b0;
            b_read_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            // Address adds truncate to ADDR_WIDTH, giving modulo-depth wrap.
            a_read_address <= a_base_q + idx[ADDR_WIDTH-1:0];
            b_read_address <= b_base_q + idx[ADDR_WIDTH-1:0];
            idx            <= idx + 1'b1;
          end
        end
        DRAIN: begin
          // The last product is still in flight; take the sum including it.
          result       <= mac_sum;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
- Sequencer that computes an unsigned dot product of two vectors held in two single-port-read mem3 instances (vector A, vector B).
- Issues paired read addresses, absorbs the 1-cycle registered read latency, multiply-accumulates, and returns the result over a valid/ready handshake.
- Sits between the FIFO-fed memory fill path and the result consumer in the dotProductFifoFSM datapath. It owns only the read ports; write ports stay with the fill logic.

Parameters:
- DATA_WIDTH, 8, width of each memory word.
- ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH (20), accumulator/result width; guarantees no overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a computation; sampled only in IDLE.
- len  in  ADDR_WIDTH+1  element count, legal range 1..2**ADDR_WIDTH.
- a_base  in  ADDR_WIDTH  start address in memory A.
- b_base  in  ADDR_WIDTH  start address in memory B.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when start is sampled with an illegal len.
- a_read_en  out  1  read enable to memory A.
- a_read_address  out  ADDR_WIDTH  read address to memory A.
- a_data  in  DATA_WIDTH  memory A data_out (valid the cycle after read_en).
- b_read_en  out  1  read enable to memory B.
- b_read_address  out  ADDR_WIDTH  read address to memory B.
- b_data  in  DATA_WIDTH  memory B data_out.
- result  out  ACC_WIDTH  dot product.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE. All outputs, the accumulator, index registers and the pipeline-valid flag go to 0. Reset mid-operation abandons the computation; no partial result is ever presented.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with 1<=len<=2**ADDR_WIDTH: latch len, a_base and b_base; clear acc and idx; go to ISSUE.
  - start=1 with an illegal len (0 or >2**ADDR_WIDTH): err=1 for the next cycle; stay in IDLE.
- ISSUE:
  - a_read_en = b_read_en = 1.
  - a_read_address = a_base+idx and b_read_address = b_base+idx, both mod 2**ADDR_WIDTH, so addresses wrap.
  - idx increments each cycle. When idx==len-1 is issued, go to DRAIN.
- Pipeline: vld_d1 is the registered read_en. On each edge where vld_d1=1, acc <= acc + a_data*b_data (unsigned, full width).
- DRAIN: read enables low. The last product accumulates on this edge, result <= final sum, result_valid <= 1, go to DONE.
- DONE: result and result_valid are held stable until result_ready=1, then result_valid <= 0 and go to IDLE. result holds its last value after that.
- Latency: with start sampled at edge 0, accumulation happens at edges 2..len+1 and result_valid rises at edge len+1. Throughput is one element per cycle.
- Boundary cases:
  - start outside IDLE is ignored, including start in the same cycle as the DONE handshake.
  - len=1 goes ISSUE(1 cycle) -> DRAIN -> DONE.
  - len=2**ADDR_WIDTH reads every address exactly once, wrapping from a_base.
  - Changing len or base inputs while busy has no effect.

Decomposition:
- Shared package dp_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - default width constants;
  - the ACC_WIDTH derivation.
- One sub-module, dp_mac: registered unsigned multiply-accumulate with clear and enable, ACC_WIDTH output.
- FSM, address generation and handshake stay in the top module.

Test Plan:
- A[0..3]={1,2,3,4}, B[0..3]={5,6,7,8}, bases 0, len=4, result_ready=1 -> result=70, result_valid rises 5 edges after start is sampled; busy is high for 6 cycles.
- a_base=14, b_base=0, len=4, A[14,15,0,1]={2,3,4,5}, B[0..3]=1 -> addresses wrap 14,15,0,1; result=14.
- len=16 with all words 8'hFF -> result=16*65025=1040400 (20'hFE010), no overflow.
- start with len=0, then again with len=17 -> err pulses one cycle each time, busy stays 0, no read enables.
- result_ready held 0 for 5 cycles after DONE, with start pulsed during the hold -> result stable; start ignored; IDLE is reached only on the ready cycle.
- rst_n dropped mid-ISSUE (len=8, after 3 reads) -> all outputs go 0 immediately. A fresh start with len=2, A={3,3}, B={2,2} -> result=12.
